text_pio_write_sequencer: RTL and testbench

- Shares the three 16-bit text PIO slaves (TextX, TextY, TextChar) between two requesters: req 0 = game logic, req 1 = score/title overlay.
- Arbitrates round-robin, latches one request, then issues three single-cycle Avalon-MM writes (X, Y, Char) to the PIO slaves in fixed order.
- Waits a settle interval, then pulses commit so the text renderer samples a coherent (X, Y, Char) triple.
- Sits between the game-control logic and the PIO output registers.

---
 rtl/text_pio_write_sequencer.sv | 151 +++++++++++++++
 tb/tb_text_pio_write_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/text_pio_write_sequencer.sv
// Round-robin sharing of the TextX/TextY/TextChar PIO slaves between two requesters.
// A granted payload is written as X, Y, Char, and a commit pulse follows after a settle interval.
module text_pio_write_sequencer #(
    parameter int unsigned DW     = 16,
    parameter int unsigned SETTLE = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req_valid,
    input  logic [DW-1:0] req0_x,
    input  logic [DW-1:0] req0_y,
    input  logic [DW-1:0] req0_char,
    input  logic [DW-1:0] req1_x,
    input  logic [DW-1:0] req1_y,
    input  logic [DW-1:0] req1_char,
    output logic [1:0]    req_ready,
    output logic [1:0]    pio_address,
    output logic [31:0]   pio_writedata,
    output logic          pio_write_n,
    output logic          cs_x,
    output logic          cs_y,
    output logic          cs_char,
    output logic          commit,
    output logic          busy,
    output logic          last_grant
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_X,
        ST_WR_Y,
        ST_WR_C,
        ST_SETTLE,
        ST_COMMIT
    } state_t;

    localparam logic [3:0] SETTLE_INIT = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    state_t        state, state_d;
    logic [3:0]    cnt, cnt_d;
    logic [DW-1:0] y_q, y_d, c_q, c_d;
    logic [1:0]    ready_d;
    logic [31:0]   wd_d;
    logic          wn_d, csx_d, csy_d, csc_d, commit_d, busy_d, lg_d;
    logic          grant;
    logic [DW-1:0] sel_x, sel_y, sel_c;

    assign pio_address = '0;

    always_comb begin
        grant = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        sel_x = grant ? req1_x    : req0_x;
        sel_y = grant ? req1_y    : req0_y;
        sel_c = grant ? req1_char : req0_char;
    end

    // X is written straight from the selected inputs in the grant cycle; only Y and Char need latching.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        y_d      = y_q;
        c_d      = c_q;
        ready_d  = '0;
        wd_d     = '0;
        wn_d     = 1'b1;
        csx_d    = 1'b0;
        csy_d    = 1'b0;
        csc_d    = 1'b0;
        commit_d = 1'b0;
        lg_d     = last_grant;
        case (state)
            ST_IDLE: begin
                if (|req_valid) begin
                    lg_d    = grant;
                    ready_d = grant ? 2'b10 : 2'b01;
                    y_d     = sel_y;
                    c_d     = sel_c;
                    state_d = ST_WR_X;
                    csx_d   = 1'b1;
                    wn_d    = 1'b0;
                    wd_d    = 32'(sel_x);
                end
            end
            ST_WR_X: begin
                state_d = ST_WR_Y;
                csy_d   = 1'b1;
                wn_d    = 1'b0;
                wd_d    = 32'(y_q);
            end
            ST_WR_Y: begin
                state_d = ST_WR_C;
                csc_d   = 1'b1;
                wn_d    = 1'b0;
                wd_d    = 32'(c_q);
            end
            ST_WR_C: begin
                if (SETTLE == 0) begin
                    state_d  = ST_COMMIT;
                    commit_d = 1'b1;
                end else begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_INIT;
                end
            end
            ST_SETTLE: begin
                if (cnt == 4'd0) begin
                    state_d  = ST_COMMIT;
                    commit_d = 1'b1;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            y_q           <= '0;
            c_q           <= '0;
            req_ready     <= '0;
            pio_writedata <= '0;
            pio_write_n   <= 1'b1;
            cs_x          <= 1'b0;
            cs_y          <= 1'b0;
            cs_char       <= 1'b0;
            commit        <= 1'b0;
            busy          <= 1'b0;
            last_grant    <= 1'b1;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            y_q           <= y_d;
            c_q           <= c_d;
            req_ready     <= ready_d;
            pio_writedata <= wd_d;
            pio_write_n   <= wn_d;
            cs_x          <= csx_d;
            cs_y          <= csy_d;
            cs_char       <= csc_d;
            commit        <= commit_d;
            busy          <= busy_d;
            last_grant    <= lg_d;
        end
    end

endmodule

// File: tb/tb_text_pio_write_sequencer.sv
// Scoreboard bench: two sequencers (SETTLE=2 and SETTLE=0) share one randomized stimulus stream;
// a timing-level reference model predicts every ready/write/commit event per instance.
module tb_text_pio_write_sequencer;

    localparam int DW = 16;
    localparam int ST [2] = '{2, 0};

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid;
    logic [DW-1:0] px [2];
    logic [DW-1:0] py [2];
    logic [DW-1:0] pc [2];

    logic [1:0]  rdy    [2];
    logic [1:0]  addr   [2];
    logic [31:0] wd     [2];
    logic        wn     [2];
    logic [2:0]  cs     [2];
    logic        cmt    [2];
    logic        bsy    [2];
    logic        lgr    [2];

    always #5 clk = ~clk;

    text_pio_write_sequencer #(.DW(DW), .SETTLE(2)) u0 (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req0_x(px[0]), .req0_y(py[0]), .req0_char(pc[0]),
        .req1_x(px[1]), .req1_y(py[1]), .req1_char(pc[1]),
        .req_ready(rdy[0]), .pio_address(addr[0]), .pio_writedata(wd[0]),
        .pio_write_n(wn[0]), .cs_x(cs[0][0]), .cs_y(cs[0][1]), .cs_char(cs[0][2]),
        .commit(cmt[0]), .busy(bsy[0]), .last_grant(lgr[0])
    );

    text_pio_write_sequencer #(.DW(DW), .SETTLE(0)) u1 (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req0_x(px[0]), .req0_y(py[0]), .req0_char(pc[0]),
        .req1_x(px[1]), .req1_y(py[1]), .req1_char(pc[1]),
        .req_ready(rdy[1]), .pio_address(addr[1]), .pio_writedata(wd[1]),
        .pio_write_n(wn[1]), .cs_x(cs[1][0]), .cs_y(cs[1][1]), .cs_char(cs[1][2]),
        .commit(cmt[1]), .busy(bsy[1]), .last_grant(lgr[1])
    );

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] data;
    } ev_t;

    ev_t wq [2][$];
    ev_t rq [2][$];
    ev_t cq [2][$];

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   free_at [2] = '{0, 0};
    int   m_lg [2] = '{1, 1};
    logic exp_busy [2] = '{1'b0, 1'b0};
    logic started [2] = '{1'b0, 1'b0};

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
        end
    endtask

    // Reference model: a grant seen in cycle c fixes the whole transaction timeline arithmetically.
    always @(posedge clk) begin
        int c;
        c = cyc;
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                started[k] = 1'b1;
                while (wq[k].size() > 0 && wq[k][$].cyc > c) void'(wq[k].pop_back());
                while (rq[k].size() > 0 && rq[k][$].cyc > c) void'(rq[k].pop_back());
                while (cq[k].size() > 0 && cq[k][$].cyc > c) void'(cq[k].pop_back());
                m_lg[k]    = 1;
                free_at[k] = c + 1;
            end else if (started[k] && c >= free_at[k] && req_valid != 2'b00) begin
                int g;
                ev_t e;
                g = (req_valid == 2'b11) ? 1 - m_lg[k] : (req_valid[1] ? 1 : 0);
                m_lg[k] = g;
                e.cyc = c + 1; e.sel = g; e.data = '0;               rq[k].push_back(e);
                e.cyc = c + 1; e.sel = 0; e.data = 32'(px[g]);       wq[k].push_back(e);
                e.cyc = c + 2; e.sel = 1; e.data = 32'(py[g]);       wq[k].push_back(e);
                e.cyc = c + 3; e.sel = 2; e.data = 32'(pc[g]);       wq[k].push_back(e);
                e.cyc = c + 4 + ST[k]; e.sel = 0; e.data = '0;       cq[k].push_back(e);
                free_at[k] = c + 5 + ST[k];
            end
            exp_busy[k] = (c + 1 < free_at[k]) && !reset;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (started[k]) begin
                int s;
                ev_t e;
                chk("cs_onehot", k, 32'($countones(cs[k]) > 1), 32'd0);
                chk("write_n", k, 32'(wn[k]), 32'(cs[k] == 3'b000));
                chk("address", k, 32'(addr[k]), 32'd0);
                chk("busy", k, 32'(bsy[k]), 32'(exp_busy[k]));
                chk("last_grant", k, 32'(lgr[k]), 32'(m_lg[k]));

                while (rq[k].size() > 0 && rq[k][0].cyc < cyc) begin
                    e = rq[k].pop_front();
                    chk("ready_missing", k, 32'(e.cyc), 32'(cyc));
                end
                if (rdy[k] != 2'b00) begin
                    if (rq[k].size() == 0) chk("ready_unexpected", k, 32'(rdy[k]), 32'd0);
                    else begin
                        e = rq[k].pop_front();
                        chk("ready_cycle", k, 32'(cyc), 32'(e.cyc));
                        chk("ready_idx", k, 32'(rdy[k]), 32'(e.sel == 1 ? 2 : 1));
                    end
                end

                while (wq[k].size() > 0 && wq[k][0].cyc < cyc) begin
                    e = wq[k].pop_front();
                    chk("write_missing", k, 32'(e.cyc), 32'(cyc));
                end
                if (cs[k] != 3'b000) begin
                    if (wq[k].size() == 0) chk("write_unexpected", k, 32'(cs[k]), 32'd0);
                    else begin
                        e = wq[k].pop_front();
                        s = cs[k][2] ? 2 : (cs[k][1] ? 1 : 0);
                        chk("write_cycle", k, 32'(cyc), 32'(e.cyc));
                        chk("write_slave", k, 32'(s), 32'(e.sel));
                        chk("write_data", k, wd[k], e.data);
                    end
                end

                while (cq[k].size() > 0 && cq[k][0].cyc < cyc) begin
                    e = cq[k].pop_front();
                    chk("commit_missing", k, 32'(e.cyc), 32'(cyc));
                end
                if (cmt[k]) begin
                    if (cq[k].size() == 0) chk("commit_unexpected", k, 32'd1, 32'd0);
                    else begin
                        e = cq[k].pop_front();
                        chk("commit_cycle", k, 32'(cyc), 32'(e.cyc));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_payload(input int i);
        px[i] = 16'($urandom);
        py[i] = 16'($urandom);
        pc[i] = 16'($urandom);
    endtask

    task automatic wait_ready(input int i);
        int n;
        n = 0;
        while (!rdy[0][i] && n < 60) begin
            step();
            n++;
        end
        if (!rdy[0][i]) begin
            miscompares++;
            $display("FAIL ready_timeout req%0d cycle %0d: got no ready within %0d cycles", i, cyc, n);
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 2'b00;
        new_payload(0);
        new_payload(1);
        repeat (3) step();
        reset = 1'b0;
        step();

        // Single request with known payload; then disturb X after ready.
        px[0] = 16'h0040; py[0] = 16'h0120; pc[0] = 16'h0041;
        req_valid = 2'b01;
        wait_ready(0);
        req_valid = 2'b00;
        px[0] = 16'hFFFF;
        repeat (12) step();

        // Contention held: grants must alternate.
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            step();
            while (rdy[0] == 2'b00) step();
            if (rdy[0][0]) new_payload(0);
            if (rdy[0][1]) new_payload(1);
        end
        req_valid = 2'b00;
        repeat (12) step();

        // Reset during WR_Y, then contention must go to requester 0.
        req_valid = 2'b01;
        wait_ready(0);
        req_valid = 2'b00;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (2) step();
        req_valid = 2'b11;
        wait_ready(0);
        req_valid = 2'b00;

        // Short pulse on requester 1 while busy.
        step();
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        repeat (12) step();

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && rdy[0][i]) begin
                    req_valid[i] = 1'b0;
                    new_payload(i);
                end else if (!req_valid[i] && ($urandom % 4) == 0) begin
                    new_payload(i);
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && ($urandom % 40) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            reset = (($urandom % 300) == 0);
            step();
        end
        reset = 1'b0;
        req_valid = 2'b00;
        repeat (40) step();

        for (int k = 0; k < 2; k++) begin
            chk("write_leftover", k, 32'(wq[k].size()), 32'd0);
            chk("ready_leftover", k, 32'(rq[k].size()), 32'd0);
            chk("commit_leftover", k, 32'(cq[k].size()), 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
